bit_demux_collector: RTL and testbench
======================================

// Module: bit_demux_collector
// PURPOSE
//  1-to-WIDTH demultiplexing collector, the write-side counterpart of the 16:1 bit-select mux.
//  Routes each incoming serial bit into bit position in_sel of a parallel word.
//  Presents the word on a valid/ready output once every position is written, or early on flush.
//  Sits between a bit-serial producer and a word-wide consumer.
// PARAMETERS
//  WIDTH   16                 number of output bit positions; power of 2, >=2
//  SEL_W   $clog2(WIDTH) (4)  width of in_sel (localparam, derived)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      in_bit/in_sel valid
//  in_ready   out  1      collector can accept a beat
//  in_bit     in   1      data bit to store
//  in_sel     in   SEL_W  destination bit position
//  flush      in   1      emit the partial word (COLLECT state only)
//  out_valid  out  1      out_data/out_mask valid
//  out_ready  in   1      consumer accepts the word
//  out_data   out  WIDTH  collected word
//  out_mask   out  WIDTH  1 = position written in this word
//  dup_err    out  1      1-cycle pulse: position overwritten within the same word
// BEHAVIOUR
//  Reset (async, rst_n=0): state=COLLECT, data=0, mask=0, out_valid=0, in_ready=0 while rst_n=0,
//   in_ready=1 from the first edge after release, dup_err=0.
//  States:
//   COLLECT: in_ready=1, out_valid=0.
//   HOLD:    in_ready=0, out_valid=1; out_data/out_mask held stable.
//  Accept (in_valid & in_ready): data[in_sel]<=in_bit, mask[in_sel]<=1.
//  COLLECT->HOLD when the post-accept mask is all ones, or when flush=1 and the post-accept mask is
//   nonzero. A beat accepted in the same cycle as flush is included in the word.
//  flush with an empty mask and no accept: ignored; it does not persist.
//  Latency: out_valid rises on the edge that accepts the completing beat; visible the next cycle.
//  HOLD->COLLECT on out_valid & out_ready: data<=0, mask<=0; in_ready=1 the following cycle.
//  Throughput: WIDTH beats + 1 cycle per word minimum; no input/output overlap.
//  in_valid while in HOLD: not accepted; producer must hold the beat (standard valid/ready).
//  out_valid must not drop, and out_data must not change, until the handshake completes.
//  Duplicate sel within a word:
//   - last write wins;
//   - dup_err is registered, high exactly one cycle after the accept; mask is unchanged.
//  Mid-word reset discards all data; no partial word is emitted.
//  out_data bits with mask=0 read 0.
// STRUCTURE
//  Package bit_demux_pkg:
//   - state enum {COLLECT, HOLD};
//   - default WIDTH constant;
//   - function returning the all-ones mask for WIDTH.
//  Sub-module bit_demux_dec (combinational): SEL_W -> WIDTH one-hot decode of in_sel,
//   gated by the accept strobe. It drives the per-bit write enables for data and mask.
//  Top level contains:
//   - the 2-state FSM;
//   - the data and mask registers;
//   - the dup_err flop;
//   - the completion/flush detect.
// TESTING
//  1 Reset held, then released -> out_valid=0, out_data=0, out_mask=0; in_ready=1 one cycle after release.
//  2 Beats sel=0..15 carrying bits of 16'hA5C3, out_ready=1 -> out_valid one cycle after the 16th
//    accept, out_data=16'hA5C3, out_mask=16'hFFFF, handshake that cycle, in_ready=1 next cycle.
//  3 Full word with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_data stable for
//    all 5 cycles; out_ready=1 -> mask clears, next beat accepted the following cycle.
//  4 sel=3 bit=1, sel=7 bit=1, then flush (no beat) -> out_data=16'h0088, out_mask=16'h0088.
//    Second case: flush together with sel=0 bit=1 -> out_data=16'h0001, out_mask=16'h0001.
//  5 sel=5 bit=1 then sel=5 bit=0 -> dup_err high one cycle after the second accept,
//    data[5]=0, mask=16'h0020. Lone flush with an empty mask -> no out_valid.
//  6 rst_n pulsed low after 8 beats (mid-cycle) -> out_valid=0, mask=0 immediately.
//    After release, a full 16-beat word 16'h1234 -> out_data=16'h1234.

Source files
------------

// File: rtl/bit_demux_pkg.sv
// ---------------------------------------------------------------------------
// bit_demux_pkg
// Shared definitions for the bit demultiplexing collector.
//   - state_e        : collector FSM states (COLLECT gathers beats, HOLD
//                      presents the finished word to the consumer)
//   - DEFAULT_WIDTH  : default number of output bit positions
//   - all_ones_mask  : helper returning a mask with the low 'width' bits set
// No ports; imported by bit_demux_dec and bit_demux_collector.
// ---------------------------------------------------------------------------
package bit_demux_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // Upper bound on the widths the helper below can describe.
  localparam int MAX_WIDTH = 256;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  // Builds the "every position written" mask. Callers truncate the result
  // to their own width.
  function automatic logic [MAX_WIDTH-1:0] all_ones_mask(input int width);
    logic [MAX_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      m[i] = (i < width);
    end
    return m;
  endfunction

endpackage

// File: rtl/bit_demux_dec.sv
// ---------------------------------------------------------------------------
// bit_demux_dec
// Combinational one-hot decoder producing per-bit write enables for the
// collector's data and mask registers.
// Ports:
//   sel_i  in   SEL_W  destination bit position
//   en_i   in   1      accept strobe; no enable is raised when low
//   we_o   out  WIDTH  one-hot write enable (all zeros when en_i=0)
// ---------------------------------------------------------------------------
module bit_demux_dec
  import bit_demux_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int SEL_W = $clog2(WIDTH)
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] we_o
);

  // WIDTH is a power of two, so every sel_i value names a real position.
  always_comb begin
    we_o = '0;
    if (en_i) begin
      we_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/bit_demux_collector.sv
// ---------------------------------------------------------------------------
// bit_demux_collector
// Collects a bit-serial stream into a parallel word: each beat writes in_bit
// into position in_sel. The word is offered on a valid/ready port once every
// position has been written, or early when flush is raised.
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      in_bit/in_sel valid
//   in_ready   out  1      collector can accept a beat
//   in_bit     in   1      data bit to store
//   in_sel     in   SEL_W  destination bit position
//   flush      in   1      emit the partial word (COLLECT only)
//   out_valid  out  1      out_data/out_mask valid
//   out_ready  in   1      consumer accepts the word
//   out_data   out  WIDTH  collected word (unwritten positions read 0)
//   out_mask   out  WIDTH  1 = position written in this word
//   dup_err    out  1      one-cycle pulse after a position is overwritten
// ---------------------------------------------------------------------------
module bit_demux_collector
  import bit_demux_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_mask,
  output logic             dup_err
);

  localparam logic [WIDTH-1:0] FULL_MASK = WIDTH'(all_ones_mask(WIDTH));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             dup_q, dup_d;
  logic             started_q;
  logic             accept;
  logic [WIDTH-1:0] we;

  // in_ready stays low through reset and the first edge after release;
  // started_q marks that the collector has seen a clock out of reset.
  assign in_ready  = started_q && (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign out_mask  = mask_q;
  assign dup_err   = dup_q;
  assign accept    = in_valid && in_ready;

  bit_demux_dec #(.WIDTH(WIDTH)) u_dec (
    .sel_i (in_sel),
    .en_i  (accept),
    .we_o  (we)
  );

  // Next-state logic. In COLLECT the addressed bit is written and the
  // post-write mask decides whether the word is finished (all positions
  // written) or flushed early (flush with at least one position written,
  // which includes a beat arriving in the same cycle). In HOLD the word is
  // frozen until the consumer takes it, then the registers are cleared so
  // unwritten positions of the next word read 0.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    dup_d   = 1'b0;
    unique case (state_q)
      COLLECT: begin
        data_d = (data_q & ~we) | (we & {WIDTH{in_bit}});
        mask_d = mask_q | we;
        dup_d  = |(mask_q & we);
        if ((mask_d == FULL_MASK) || (flush && (mask_d != '0))) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = COLLECT;
          data_d  = '0;
          mask_d  = '0;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // State, word and error registers. Reset discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      data_q    <= '0;
      mask_q    <= '0;
      dup_q     <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      dup_q     <= dup_d;
      started_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bit_demux_collector.sv
// ---------------------------------------------------------------------------
// tb_bit_demux_collector
// Self-checking bench for bit_demux_collector: directed scenarios plus a
// randomized run, all checked against a word-level reference model.
// ---------------------------------------------------------------------------
module tb_bit_demux_collector;

  localparam int WIDTH = 16;
  localparam int SEL_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic [SEL_W-1:0] in_sel;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] out_mask;
  logic             dup_err;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: the word under construction, which positions hold a
  // value, whether a finished word is waiting for the consumer, and whether
  // the last accepted beat overwrote a position.
  logic [WIDTH-1:0] mData;
  logic [WIDTH-1:0] mMask;
  bit               mHold;
  bit               mStarted;
  bit               mDup;

  bit_demux_collector #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_sel    (in_sel),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mask  (out_mask),
    .dup_err   (dup_err)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    mData    = '0;
    mMask    = '0;
    mHold    = 0;
    mStarted = 0;
    mDup     = 0;
  endtask

  // Advance the model by one clock using the inputs presented in that cycle.
  task automatic model_step(input logic v, input logic b, input logic [SEL_W-1:0] s,
                            input logic f, input logic r);
    bit acc;
    acc  = v && mStarted && !mHold;
    mDup = 0;
    if (mHold) begin
      if (r) begin
        mHold = 0;
        mData = '0;
        mMask = '0;
      end
    end else begin
      if (acc) begin
        if (mMask[s]) mDup = 1;
        mData[s] = b;
        mMask[s] = 1'b1;
      end
      if (mMask == 16'hFFFF || (f && mMask != 16'h0000)) mHold = 1;
    end
    mStarted = 1;
  endtask

  // Present inputs at a falling edge, let one rising edge pass, return at
  // the next falling edge with the model advanced in step.
  task automatic drive(input logic v, input logic b, input logic [SEL_W-1:0] s,
                       input logic f, input logic r);
    in_valid  = v;
    in_bit    = b;
    in_sel    = s;
    flush     = f;
    out_ready = r;
    @(posedge clk);
    model_step(v, b, s, f, r);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid);
    end
    compared++;
    if (out_data !== 16'h0000 || out_mask !== 16'h0000) begin
      mismatched++;
      $display("[TB] FAIL reset_word: got data=%h mask=%h want 0000/0000", out_data, out_mask);
    end
    compared++;
    if (in_ready !== 1'b0 || dup_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ready_dup: got ready=%b dup=%b want 0/0", in_ready, dup_err);
    end
    rst_n = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL release_ready_early: got %b want 0", in_ready);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_full_word();
    logic [WIDTH-1:0] word;
    bit early;
    word  = 16'hA5C3;
    early = 0;
    for (int i = 0; i < WIDTH; i++) begin
      drive(1, word[i], SEL_W'(i), 0, 1);
      if (i < WIDTH - 1 && out_valid !== 1'b0) early = 1;
    end
    compared++;
    if (early) begin
      mismatched++;
      $display("[TB] FAIL full_no_early_valid: got out_valid=1 before 16th beat want 0");
    end
    compared++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL full_valid: got valid=%b ready=%b want 1/0", out_valid, in_ready);
    end
    compared++;
    if (out_data !== 16'hA5C3 || out_mask !== 16'hFFFF) begin
      mismatched++;
      $display("[TB] FAIL full_word: got data=%h mask=%h want a5c3/ffff", out_data, out_mask);
    end
    drive(0, 0, 0, 0, 1);
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_mask !== 16'h0000) begin
      mismatched++;
      $display("[TB] FAIL full_handshake: got valid=%b ready=%b mask=%h want 0/1/0000",
               out_valid, in_ready, out_mask);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] held;
    bit unstable;
    word     = 16'($urandom);
    unstable = 0;
    for (int i = 0; i < WIDTH; i++) drive(1, word[i], SEL_W'(i), 0, 0);
    held = out_data;
    compared++;
    if (held !== word) begin
      mismatched++;
      $display("[TB] FAIL bp_word: got %h want %h", held, word);
    end
    for (int c = 0; c < 5; c++) begin
      drive(1, 1, 4'd9, 0, 0);
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) unstable = 1;
    end
    compared++;
    if (unstable) begin
      mismatched++;
      $display("[TB] FAIL bp_hold: got ready=%b valid=%b data=%h want 0/1/%h",
               in_ready, out_valid, out_data, held);
    end
    drive(1, 1, 4'd9, 0, 1);
    compared++;
    if (out_mask !== 16'h0000 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL bp_release: got mask=%h valid=%b ready=%b want 0000/0/1",
               out_mask, out_valid, in_ready);
    end
    drive(1, 1, 4'd9, 0, 1);
    compared++;
    if (out_mask !== 16'h0200 || out_data !== 16'h0200) begin
      mismatched++;
      $display("[TB] FAIL bp_next_beat: got data=%h mask=%h want 0200/0200", out_data, out_mask);
    end
    // Emit the one-beat word so later tests start from an empty collector.
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1);
  endtask

  task automatic test_flush();
    drive(1, 1, 4'd3, 0, 0);
    drive(1, 1, 4'd7, 0, 0);
    drive(0, 0, 4'd0, 1, 0);
    compared++;
    if (out_valid !== 1'b1 || out_data !== 16'h0088 || out_mask !== 16'h0088) begin
      mismatched++;
      $display("[TB] FAIL flush_partial: got valid=%b data=%h mask=%h want 1/0088/0088",
               out_valid, out_data, out_mask);
    end
    drive(0, 0, 0, 0, 1);
    drive(1, 1, 4'd0, 1, 0);
    compared++;
    if (out_valid !== 1'b1 || out_data !== 16'h0001 || out_mask !== 16'h0001) begin
      mismatched++;
      $display("[TB] FAIL flush_with_beat: got valid=%b data=%h mask=%h want 1/0001/0001",
               out_valid, out_data, out_mask);
    end
    drive(0, 0, 0, 0, 1);
  endtask

  task automatic test_duplicate();
    drive(1, 1, 4'd5, 0, 0);
    compared++;
    if (dup_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL dup_first_write: got %b want 0", dup_err);
    end
    drive(1, 0, 4'd5, 0, 0);
    compared++;
    if (dup_err !== 1'b1 || out_mask !== 16'h0020 || out_data[5] !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL dup_overwrite: got dup=%b mask=%h data=%h want 1/0020/bit5=0",
               dup_err, out_mask, out_data);
    end
    drive(0, 0, 0, 0, 0);
    compared++;
    if (dup_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL dup_pulse_width: got %b want 0", dup_err);
    end
    drive(0, 0, 0, 1, 0);
    compared++;
    if (out_valid !== 1'b1 || out_data !== 16'h0000 || out_mask !== 16'h0020) begin
      mismatched++;
      $display("[TB] FAIL dup_flush: got valid=%b data=%h mask=%h want 1/0000/0020",
               out_valid, out_data, out_mask);
    end
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 0);
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL empty_flush: got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    drive(0, 0, 0, 0, 0);
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL empty_flush_persist: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_midword_reset();
    logic [WIDTH-1:0] word;
    for (int i = 0; i < 8; i++) drive(1, 1, SEL_W'(i), 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compared++;
    if (out_valid !== 1'b0 || out_mask !== 16'h0000 || in_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midreset: got valid=%b mask=%h ready=%b want 0/0000/0",
               out_valid, out_mask, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 1);
    word = 16'h1234;
    for (int i = 0; i < WIDTH; i++) drive(1, word[i], SEL_W'(i), 0, 1);
    compared++;
    if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_mask !== 16'hFFFF) begin
      mismatched++;
      $display("[TB] FAIL after_reset_word: got valid=%b data=%h mask=%h want 1/1234/ffff",
               out_valid, out_data, out_mask);
    end
    drive(0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    int errs;
    logic v, b, f, r;
    logic [SEL_W-1:0] s;
    errs = 0;
    for (int c = 0; c < 600; c++) begin
      v = ($urandom_range(3) != 0);
      b = 1'($urandom);
      s = SEL_W'($urandom);
      f = ($urandom_range(11) == 0);
      r = 1'($urandom);
      drive(v, b, s, f, r);
      compared++;
      if (in_ready !== (mStarted && !mHold) || out_valid !== mHold ||
          out_data !== mData || out_mask !== mMask || dup_err !== mDup) begin
        mismatched++;
        errs++;
        if (errs <= 5)
          $display("[TB] FAIL random_cycle_%0d: got rdy=%b vld=%b data=%h mask=%h dup=%b want %b/%b/%h/%h/%b",
                   c, in_ready, out_valid, out_data, out_mask, dup_err,
                   (mStarted && !mHold), mHold, mData, mMask, mDup);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    in_sel    = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_full_word();
    test_back_to_back();
    test_flush();
    test_duplicate();
    test_midword_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
